delta_w2_21: RTL and testbench
==============================

DELTA_W2_21 -- requirements
Module: delta_w2_21

Parameters
REQ-001 SHALL: ETA, default 16'sd51 (0.0498 in Q6.10), learning rate, signed Q6.10.

Interface
REQ-002 SHALL: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL: start  input  1  request to compute one delta weight; sampled only in IDLE.
REQ-005 SHALL: delta2_2  input  16  output-neuron-2 error term, signed Q6.10 (00_0000.0000_0000_00).
REQ-006 SHALL: a1_1  input  16  hidden-neuron-1 activation, signed Q6.10.
REQ-007 SHALL: busy  output  1  high whenever the state is not IDLE.
REQ-008 SHALL: select_update  output  1  one-cycle pulse marking dw2_21 as new; drives the weight register's update select.
REQ-009 SHALL: dw2_21  output  16  delta weight, signed Q6.10, held until the next result.

Function
REQ-010 SHALL: dw2_21 = -(ETA * (delta2_2 * a1_1)), computed in two sequential multiplies.
REQ-011 SHALL: FSM states are IDLE, MUL1, MUL2 and DONE; all outputs are registered.
REQ-012 SHALL: in IDLE with start=1 at edge N, capture delta2_2 and a1_1, then enter MUL1. Input changes after edge N are ignored.
REQ-013 SHALL: MUL1 performs 16 shift-add iterations on edges N+1..N+16 to form the exact signed 32-bit product p1 = delta2_2*a1_1 (Q12.20), then enters MUL2.
REQ-014 SHALL: p1 is reduced to Q6.10 by arithmetic right shift by 10 (floor), then saturated to [-32768, 32767], giving q1.
REQ-015 SHALL: MUL2 performs 16 iterations on edges N+17..N+32 to form ETA*q1, reduced and saturated as in REQ-014, giving q2.
REQ-016 SHALL: at edge N+32, dw2_21 is loaded with -q2 and the state becomes DONE. The negation saturates: -(-32768) gives 32767.
REQ-017 SHALL: select_update is high only during the DONE cycle, i.e. between edges N+32 and N+33.
REQ-018 SHALL: DONE returns to IDLE at edge N+33; the earliest next accept is edge N+34, giving a 34-cycle period.
REQ-019 SHALL: start while busy=1 is ignored, with no queueing and no effect on the current result.
REQ-020 SHALL: start held high continuously yields one result every 34 cycles, each using the inputs present at its own accept edge.
REQ-021 SHALL: products are exact; no intermediate truncation inside a multiply. Rounding and saturation occur only per REQ-014, REQ-015 and REQ-016.
REQ-022 SHALL: a zero operand yields dw2_21 = 0, still with the full 32-cycle latency and a select_update pulse.
REQ-023 SHALL: dw2_21 is never changed except at the edge entering DONE, or by reset.

Reset
REQ-024 SHALL: while reset=1, at each edge: state goes to IDLE, busy=0, select_update=0, dw2_21=16'h0000, and all internal accumulators are cleared.
REQ-025 SHALL: reset has priority over start and over every FSM transition.
REQ-026 SHALL: reset asserted mid-operation aborts the operation with no select_update pulse; start is accepted again from the first edge after reset deasserts.

Verification
REQ-027 SHALL: reset for 2 cycles, then idle -> busy=0, select_update=0, dw2_21=0x0000.
REQ-028 SHALL: delta2_2=1024 (1.0), a1_1=512 (0.5), ETA=51, start at edge N -> q1=512, q2=25; select_update high after edge N+32 for one cycle; dw2_21=-25 (0xFFE7).
REQ-029 SHALL: delta2_2=-1024, a1_1=512 -> q1=-512, q2=floor(-25.5)=-26; dw2_21=+26 (0x001A).
REQ-030 SHALL: delta2_2=32767, a1_1=32767 -> q1 saturates to 32767, q2=1631; dw2_21=-1631 (0xF9A1).
REQ-031 SHALL: start pulsed at N+5 and N+20 during an operation -> ignored; exactly one pulse at N+32. Separately, reset at N+10 -> no pulse; dw2_21=0; busy=0 at N+11.
REQ-032 SHALL: start held high with inputs changing every cycle -> accepts at N, N+34, N+68; each dw2_21 matches the inputs sampled at its own accept edge.

Source files
------------

// File: rtl/delta_w2_21.sv
// delta_w2_21: dw2_21 = -(ETA * (delta2_2 * a1_1)), signed Q6.10, two
// sequential 16-step shift-add multiplies. Ports: clk, reset (sync, high),
// start, delta2_2, a1_1 in; busy, select_update, dw2_21 out (registered).
module delta_w2_21 #(
  parameter logic signed [15:0] ETA = 16'sd51
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] delta2_2,
  input  logic [15:0] a1_1,
  output logic        busy,
  output logic        select_update,
  output logic [15:0] dw2_21
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic        busy_q, busy_d;
  logic        sel_q, sel_d;
  logic [15:0] dw_q, dw_d;

  logic [31:0] addend;
  logic [31:0] sum;
  logic [15:0] red;

  // Q12.20 -> Q6.10: floor shift by 10, then clamp to 16 bits.
  function automatic logic [15:0] red_sat(
    input logic [31:0] p
  );
    logic [21:0] s;
    s = p[31:10];
    if (s[21:15] == {7{s[21]}})
      red_sat = s[15:0];
    else if (s[21])
      red_sat = 16'h8000;
    else
      red_sat = 16'h7fff;
  endfunction

  function automatic logic [15:0] neg_sat(
    input logic [15:0] x
  );
    if (x == 16'h8000)
      neg_sat = 16'h7fff;
    else
      neg_sat = 16'h0000 - x;
  endfunction

  // Step 15 carries the multiplier sign bit, weight -2^15.
  always_comb begin
    addend = mplier_q[0] ? mcand_q : 32'd0;
    if (cnt_q == 4'd15)
      sum = acc_q - addend;
    else
      sum = acc_q + addend;
    red = red_sat(sum);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    dw_d     = dw_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{16{delta2_2[15]}}, delta2_2};
          mplier_d = a1_1;
          acc_d    = 32'd0;
          cnt_d    = 4'd0;
          state_d  = MUL1;
        end
      end
      MUL1: begin
        acc_d    = sum;
        mcand_d  = {mcand_q[30:0], 1'b0};
        mplier_d = {1'b0, mplier_q[15:1]};
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          mcand_d  = {{16{ETA[15]}}, ETA};
          mplier_d = red;
          acc_d    = 32'd0;
          state_d  = MUL2;
        end
      end
      MUL2: begin
        acc_d    = sum;
        mcand_d  = {mcand_q[30:0], 1'b0};
        mplier_d = {1'b0, mplier_q[15:1]};
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          dw_d    = neg_sat(red);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    sel_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 16'd0;
      acc_q    <= 32'd0;
      busy_q   <= 1'b0;
      sel_q    <= 1'b0;
      dw_q     <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      sel_q    <= sel_d;
      dw_q     <= dw_d;
    end
  end

  assign busy          = busy_q;
  assign select_update = sel_q;
  assign dw2_21        = dw_q;

endmodule

// File: tb/tb_delta_w2_21.sv
// tb_delta_w2_21: scoreboard bench for delta_w2_21.
// Cycle-level timing model plus queue of expected dw2_21 values.
module tb_delta_w2_21;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] delta2_2;
  logic [15:0] a1_1;
  logic        busy;
  logic        select_update;
  logic [15:0] dw2_21;

  int errors;
  int checks;

  logic [15:0] sb_q[$];
  logic [15:0] hold;
  int          m_cnt;
  logic        m_rst;
  logic        run_mon;

  delta_w2_21 dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .delta2_2      (delta2_2),
    .a1_1          (a1_1),
    .busy          (busy),
    .select_update (select_update),
    .dw2_21        (dw2_21)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767)
      return 32767;
    if (v < -32768)
      return -32768;
    return v;
  endfunction

  function automatic logic [15:0] exp_dw(
    input logic [15:0] d,
    input logic [15:0] a
  );
    longint p1, q1, p2, q2, r;
    p1 = longint'($signed(d)) * longint'($signed(a));
    q1 = sat16(p1 >>> 10);
    p2 = 51 * q1;
    q2 = sat16(p2 >>> 10);
    r  = sat16(-q2);
    return r[15:0];
  endfunction

  // Timing model: 1 after accept edge, 33 in DONE, 0 idle.
  always @(posedge clk) begin
    m_rst <= reset;
    if (reset) begin
      m_cnt <= 0;
      sb_q.delete();
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt <= 1;
        sb_q.push_back(exp_dw(delta2_2, a1_1));
      end
    end else if (m_cnt == 33) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (run_mon) begin
      if (m_rst)
        hold = 16'h0000;
      chk("busy", {15'd0, busy},
          {15'd0, m_cnt != 0});
      chk("select_update", {15'd0, select_update},
          {15'd0, m_cnt == 33});
      if (m_cnt == 33) begin
        if (sb_q.size() == 0)
          chk("sb_underflow", 16'd1, 16'd0);
        else
          hold = sb_q.pop_front();
      end
      chk("dw2_21", dw2_21, hold);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_op(
    input logic [15:0] d,
    input logic [15:0] a
  );
    delta2_2 = d;
    a1_1     = a;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    delta2_2 = 16'($urandom);
    a1_1     = 16'($urandom);
    repeat (33) tick();
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    hold     = 16'h0000;
    run_mon  = 1'b1;
    reset    = 1'b1;
    start    = 1'b0;
    delta2_2 = 16'd0;
    a1_1     = 16'd0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("reset_dw", dw2_21, 16'h0000);
    chk("reset_busy", {15'd0, busy}, 16'd0);

    do_op(16'd1024, 16'd512);
    chk("pos_half", dw2_21, 16'hffe7);
    do_op(16'hfc00, 16'd512);
    chk("neg_floor", dw2_21, 16'h001a);
    do_op(16'h7fff, 16'h7fff);
    chk("sat_q1", dw2_21, 16'hf9a1);
    do_op(16'h8000, 16'h8000);
    do_op(16'h0000, 16'h1234);
    chk("zero_op", dw2_21, 16'h0000);
    do_op(16'h8000, 16'h7fff);
    do_op(16'h0400, 16'hffff);

    // start pulses while busy must be ignored
    delta2_2 = 16'd3000;
    a1_1     = 16'hf000;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    delta2_2 = 16'd77;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();

    // reset mid-operation aborts
    delta2_2 = 16'd1024;
    a1_1     = 16'd1024;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_dw", dw2_21, 16'h0000);
    repeat (2) tick();

    for (int i = 0; i < 4; i++)
      do_op(16'($urandom), 16'($urandom));

    // continuous start with inputs changing every cycle
    start = 1'b1;
    for (int i = 0; i < 102; i++) begin
      delta2_2 = 16'($urandom);
      a1_1     = 16'($urandom);
      tick();
    end
    start = 1'b0;

    for (int i = 0; i < 100 && m_cnt != 0; i++)
      tick();
    tick();
    chk("drain_idle", {15'd0, busy}, 16'd0);
    chk("drain_queue", 16'(sb_q.size()), 16'd0);
    run_mon = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
